pkt_bufid_allocator: RTL and testbench

//  Free-list manager for packet buffer IDs (PCB slots of 128 words, addr = {bufid,7'd0}).

---
 rtl/pkt_bufid_allocator_pkg.sv | 22 ++
 rtl/pkt_bufid_allocator_if.sv | 31 +++
 rtl/pkt_bufid_allocator_bufid_free_fifo.sv | 68 ++++++
 rtl/pkt_bufid_allocator.sv | 144 ++++++++++++++
 tb/tb_pkt_bufid_allocator.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/pkt_bufid_allocator_pkg.sv
// Shared constants for the packet buffer-ID allocator: default sizing,
// PCB geometry and FSM state encodings.
package pkt_bufid_allocator_pkg;

  localparam int PKT_BUF_NUM   = 512;
  localparam int PKT_BUFID_W   = 9;
  localparam int PCB_WORDS     = 128;
  localparam int PCB_WORD_W    = 7;
  localparam int PCB_ADDR_W    = PKT_BUFID_W + PCB_WORD_W;

  typedef enum logic [1:0] {
    INIT_S  = 2'b00,
    ISSUE_S = 2'b01,
    HOLD_S  = 2'b10
  } alloc_state_t;

  // Base word address of a PCB slot: each buffer owns 128 consecutive words.
  function automatic logic [PCB_ADDR_W-1:0] pcb_base_addr(input logic [PKT_BUFID_W-1:0] id);
    return {id, {PCB_WORD_W{1'b0}}};
  endfunction

endpackage

// File: rtl/pkt_bufid_allocator_if.sv
// Issue/release handshake between the buffer-ID allocator and its neighbours.
// Signal names are seen from the allocator: master = allocator, slave = user.
interface pkt_bufid_allocator_if
  import pkt_bufid_allocator_pkg::*;
#(
  parameter int BUFID_W = PKT_BUFID_W
) ();

  logic               i_bufid_req;
  logic               o_bufid_wr;
  logic [BUFID_W-1:0] ov_bufid;
  logic               i_bufid_rel_wr;
  logic [BUFID_W-1:0] iv_bufid_rel;

  modport master (
    input  i_bufid_req,
    input  i_bufid_rel_wr,
    input  iv_bufid_rel,
    output o_bufid_wr,
    output ov_bufid
  );

  modport slave (
    output i_bufid_req,
    output i_bufid_rel_wr,
    output iv_bufid_rel,
    input  o_bufid_wr,
    input  ov_bufid
  );

endinterface

// File: rtl/pkt_bufid_allocator_bufid_free_fifo.sv
// Circular RAM FIFO holding free buffer IDs. Push/pop are self-guarded
// against overflow/underflow; count and empty flag are registered and
// reflect the state after this cycle's push/pop.
module bufid_free_fifo #(
  parameter int BUF_NUM = 512,
  parameter int BUFID_W = 9
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_push,
  input  logic [BUFID_W-1:0] iv_push_id,
  input  logic               i_pop,
  output logic [BUFID_W-1:0] ov_head,
  output logic [BUFID_W:0]   ov_count,
  output logic               o_empty
);

  localparam logic [BUFID_W-1:0] LAST_IDX = BUFID_W'(BUF_NUM - 1);
  localparam logic [BUFID_W:0]   FULL_CNT = (BUFID_W+1)'(BUF_NUM);

  logic [BUFID_W-1:0] r_mem [BUF_NUM];
  logic [BUFID_W-1:0] r_wr_ptr;
  logic [BUFID_W-1:0] r_rd_ptr;
  logic [BUFID_W:0]   r_count;
  logic               r_empty;
  logic               w_push_ok;
  logic               w_pop_ok;
  logic [BUFID_W:0]   w_count_nxt;

  assign w_push_ok = i_push && (r_count != FULL_CNT);
  assign w_pop_ok  = i_pop  && (r_count != '0);
  assign ov_head   = r_mem[r_rd_ptr];
  assign ov_count  = r_count;
  assign o_empty   = r_empty;

  // Next occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop_ok)
      w_count_nxt = r_count + 1'b1;
    else if (!w_push_ok && w_pop_ok)
      w_count_nxt = r_count - 1'b1;
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge i_clk) begin
    if (w_push_ok)
      r_mem[r_wr_ptr] <= iv_push_id;
  end

  // Pointers wrap at BUF_NUM-1 so non-power-of-two depths also work.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b0;
    end else begin
      if (w_push_ok)
        r_wr_ptr <= (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop_ok)
        r_rd_ptr <= (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
    end
  end

endmodule

// File: rtl/pkt_bufid_allocator.sv
// Packet buffer-ID free-list manager. Fills the free list with 0..BUF_NUM-1
// after reset, then hands one ID at a time downstream and refills after the
// consumer signals that the ID was taken. Returned IDs are pushed at the tail.
// Optional build macro BUFID_DOUBLE_FREE_CHK_EN adds an allocated-ID bitmap
// that rejects releases of IDs that are not currently allocated.
module pkt_bufid_allocator
  import pkt_bufid_allocator_pkg::*;
#(
  parameter int BUF_NUM = PKT_BUF_NUM,
  parameter int BUFID_W = PKT_BUFID_W
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  pkt_bufid_allocator_if.master      bif,
  output logic [BUFID_W:0]           ov_free_bufid_num,
  output logic                       o_bufid_empty,
  output logic                       o_rel_err,
  output logic [1:0]                 ov_alloc_state
);

  localparam logic [BUFID_W-1:0] LAST_IDX = BUFID_W'(BUF_NUM - 1);
  localparam logic [BUFID_W:0]   FULL_CNT = (BUFID_W+1)'(BUF_NUM);

  alloc_state_t       r_state;
  alloc_state_t       w_state_nxt;
  logic [BUFID_W-1:0] r_init_cnt;
  logic               r_bufid_wr;
  logic [BUFID_W-1:0] r_bufid;
  logic               r_rel_err;
  logic               w_push;
  logic [BUFID_W-1:0] w_push_id;
  logic               w_pop;
  logic               w_rel_ok;
  logic               w_rel_drop;
  logic               w_alloc_ok;
  logic [BUFID_W-1:0] w_head;
  logic [BUFID_W:0]   w_count;
  logic               w_empty;

  bufid_free_fifo #(
    .BUF_NUM (BUF_NUM),
    .BUFID_W (BUFID_W)
  ) u_free_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (w_push),
    .iv_push_id (w_push_id),
    .i_pop      (w_pop),
    .ov_head    (w_head),
    .ov_count   (w_count),
    .o_empty    (w_empty)
  );

`ifdef BUFID_DOUBLE_FREE_CHK_EN
  logic [BUF_NUM-1:0] r_alloc_map;

  assign w_alloc_ok = r_alloc_map[iv_rel_idx()];

  function automatic logic [BUFID_W-1:0] iv_rel_idx();
    return bif.iv_bufid_rel;
  endfunction

  // Track IDs currently handed out: set when issued, clear when returned.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_alloc_map <= '0;
    end else if (r_state == INIT_S) begin
      r_alloc_map <= '0;
    end else begin
      if (w_rel_ok)
        r_alloc_map[bif.iv_bufid_rel] <= 1'b0;
      if (w_pop)
        r_alloc_map[w_head] <= 1'b1;
    end
  end
`else
  assign w_alloc_ok = 1'b1;
`endif

  // Next state, free-list push/pop selection and release acceptance.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_push_id   = bif.iv_bufid_rel;
    w_pop       = 1'b0;
    w_rel_ok    = 1'b0;
    w_rel_drop  = 1'b0;
    case (r_state)
      INIT_S: begin
        w_push     = 1'b1;
        w_push_id  = r_init_cnt;
        w_rel_drop = bif.i_bufid_rel_wr;
        if (r_init_cnt == LAST_IDX)
          w_state_nxt = ISSUE_S;
      end
      ISSUE_S: begin
        if (w_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = HOLD_S;
        end
      end
      HOLD_S: begin
        if (bif.i_bufid_req)
          w_state_nxt = ISSUE_S;
      end
      default: w_state_nxt = INIT_S;
    endcase
    if (r_state != INIT_S && bif.i_bufid_rel_wr) begin
      if (w_count != FULL_CNT && w_alloc_ok) begin
        w_push   = 1'b1;
        w_rel_ok = 1'b1;
      end else begin
        w_rel_drop = 1'b1;
      end
    end
  end

  // State register, init counter and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= INIT_S;
      r_init_cnt <= '0;
      r_bufid_wr <= 1'b0;
      r_bufid    <= '0;
      r_rel_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bufid_wr <= w_pop;
      r_rel_err  <= w_rel_drop;
      if (r_state == INIT_S)
        r_init_cnt <= r_init_cnt + 1'b1;
      if (w_pop)
        r_bufid <= w_head;
    end
  end

  assign bif.o_bufid_wr    = r_bufid_wr;
  assign bif.ov_bufid      = r_bufid;
  assign ov_free_bufid_num = w_count;
  assign o_bufid_empty     = w_empty;
  assign o_rel_err         = r_rel_err;
  assign ov_alloc_state    = r_state;

endmodule

// File: tb/tb_pkt_bufid_allocator.sv
// Directed self-checking bench for pkt_bufid_allocator (BUF_NUM=512).
module tb_pkt_bufid_allocator;

  localparam int N = 512;
  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W:0]   free_num;
  logic         empty;
  logic         rel_err;
  logic [1:0]   st;
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  pkt_bufid_allocator_if #(.BUFID_W(W)) bif();

  pkt_bufid_allocator #(.BUF_NUM(N), .BUFID_W(W)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .bif               (bif),
    .ov_free_bufid_num (free_num),
    .o_bufid_empty     (empty),
    .o_rel_err         (rel_err),
    .ov_alloc_state    (st)
  );

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
    $fatal(1);
  end

  // Wait (bounded) for the first issue pulse after reset; cycles = negedges waited.
  task automatic wait_first_wr(output bit seen, output int cycles);
    seen = 1'b0;
    cycles = -1;
    for (int i = 0; i < N + 20; i++) begin
      @(negedge clk);
      if (bif.o_bufid_wr === 1'b1) begin
        seen = 1'b1;
        cycles = i;
        break;
      end
    end
  endtask

  // One request pulse; returns wr one cycle later (mid) and two cycles later.
  task automatic issue_one(output logic wr_mid, output logic wr, output logic [W-1:0] id);
    @(negedge clk);
    bif.i_bufid_req = 1'b1;
    @(negedge clk);
    bif.i_bufid_req = 1'b0;
    wr_mid = bif.o_bufid_wr;
    @(negedge clk);
    wr = bif.o_bufid_wr;
    id = bif.ov_bufid;
  endtask

  // One release pulse; returns after the cycle in which it was sampled.
  task automatic release_one(input logic [W-1:0] id);
    @(negedge clk);
    bif.i_bufid_rel_wr = 1'b1;
    bif.iv_bufid_rel   = id;
    @(negedge clk);
    bif.i_bufid_rel_wr = 1'b0;
  endtask

  task automatic test_reset;
    bif.i_bufid_req    = 1'b0;
    bif.i_bufid_rel_wr = 1'b0;
    bif.iv_bufid_rel   = '0;
    #3 rst_n = 1'b0;
    #12;
    checks++; if (bif.o_bufid_wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %0b want 0", bif.o_bufid_wr); end
    checks++; if (bif.ov_bufid !== 9'd0) begin errors++; $display("FAIL reset_bufid: got %0d want 0", bif.ov_bufid); end
    checks++; if (free_num !== 10'd0) begin errors++; $display("FAIL reset_free_num: got %0d want 0", free_num); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL reset_empty: got %0b want 0", empty); end
    checks++; if (rel_err !== 1'b0) begin errors++; $display("FAIL reset_rel_err: got %0b want 0", rel_err); end
    checks++; if (st !== 2'b00) begin errors++; $display("FAIL reset_state: got %0d want 0", st); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_init;
    bit seen;
    int cyc;
    bif.i_bufid_rel_wr = 1'b1;
    bif.iv_bufid_rel   = 9'd3;
    @(negedge clk);
    bif.i_bufid_rel_wr = 1'b0;
    checks++; if (rel_err !== 1'b1) begin errors++; $display("FAIL init_rel_err: got %0b want 1", rel_err); end
    checks++; if (free_num !== 10'd1) begin errors++; $display("FAIL init_count1: got %0d want 1", free_num); end
    @(negedge clk);
    checks++; if (rel_err !== 1'b0) begin errors++; $display("FAIL init_rel_err_pulse: got %0b want 0", rel_err); end
    wait_first_wr(seen, cyc);
    checks++; if (!seen) begin errors++; $display("FAIL init_first_wr: got none want pulse"); end
    checks++; if (cyc !== 510) begin errors++; $display("FAIL init_latency: got %0d want 510", cyc); end
    checks++; if (bif.ov_bufid !== 9'd0) begin errors++; $display("FAIL init_first_id: got %0d want 0", bif.ov_bufid); end
    checks++; if (free_num !== 10'd511) begin errors++; $display("FAIL init_free_num: got %0d want 511", free_num); end
    checks++; if (st !== 2'b10) begin errors++; $display("FAIL init_hold_state: got %0d want 2", st); end
  endtask

  task automatic test_latency;
    logic wm, wr;
    logic [W-1:0] id;
    for (int k = 1; k <= 2; k++) begin
      issue_one(wm, wr, id);
      checks++; if (wm !== 1'b0) begin errors++; $display("FAIL lat_early_wr[%0d]: got %0b want 0", k, wm); end
      checks++; if (wr !== 1'b1 || id !== W'(k)) begin errors++; $display("FAIL lat_issue[%0d]: got wr=%0b id=%0d want wr=1 id=%0d", k, wr, id, k); end
      checks++; if (free_num !== 10'(N - 1 - k)) begin errors++; $display("FAIL lat_free_num[%0d]: got %0d want %0d", k, free_num, N - 1 - k); end
    end
  endtask

  task automatic test_drain;
    logic wm, wr;
    logic [W-1:0] id;
    for (int k = 3; k < N; k++) begin
      issue_one(wm, wr, id);
      checks++; if (wr !== 1'b1 || id !== W'(k)) begin errors++; $display("FAIL drain_id[%0d]: got wr=%0b id=%0d want wr=1 id=%0d", k, wr, id, k); end
    end
    checks++; if (free_num !== 10'd0) begin errors++; $display("FAIL drain_free_num: got %0d want 0", free_num); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %0b want 1", empty); end
    issue_one(wm, wr, id);
    checks++; if (wm !== 1'b0 || wr !== 1'b0) begin errors++; $display("FAIL drain_no_wr: got %0b/%0b want 0/0", wm, wr); end
    checks++; if (st !== 2'b01) begin errors++; $display("FAIL drain_issue_state: got %0d want 1", st); end
  endtask

  task automatic test_release_empty;
    release_one(9'd5);
    checks++; if (free_num !== 10'd1 || bif.o_bufid_wr !== 1'b0) begin errors++; $display("FAIL relempty_push: got num=%0d wr=%0b want num=1 wr=0", free_num, bif.o_bufid_wr); end
    checks++; if (rel_err !== 1'b0) begin errors++; $display("FAIL relempty_err: got %0b want 0", rel_err); end
    @(negedge clk);
    checks++; if (bif.o_bufid_wr !== 1'b1 || bif.ov_bufid !== 9'd5) begin errors++; $display("FAIL relempty_issue: got wr=%0b id=%0d want wr=1 id=5", bif.o_bufid_wr, bif.ov_bufid); end
    checks++; if (free_num !== 10'd0 || empty !== 1'b1) begin errors++; $display("FAIL relempty_num: got num=%0d empty=%0b want 0/1", free_num, empty); end
  endtask

  task automatic test_rel_pop_same;
    logic wm, wr;
    logic [W-1:0] id;
    for (int j = 0; j < 10; j++) release_one(W'(100 + j));
    checks++; if (free_num !== 10'd10 || rel_err !== 1'b0) begin errors++; $display("FAIL same_fill: got num=%0d err=%0b want 10/0", free_num, rel_err); end
    @(negedge clk);
    bif.i_bufid_req = 1'b1;
    @(negedge clk);
    bif.i_bufid_req    = 1'b0;
    bif.i_bufid_rel_wr = 1'b1;
    bif.iv_bufid_rel   = 9'd200;
    @(negedge clk);
    bif.i_bufid_rel_wr = 1'b0;
    checks++; if (bif.o_bufid_wr !== 1'b1 || bif.ov_bufid !== 9'd100) begin errors++; $display("FAIL same_issue: got wr=%0b id=%0d want wr=1 id=100", bif.o_bufid_wr, bif.ov_bufid); end
    checks++; if (free_num !== 10'd10) begin errors++; $display("FAIL same_count: got %0d want 10", free_num); end
    for (int j = 1; j < 10; j++) begin
      issue_one(wm, wr, id);
      checks++; if (wr !== 1'b1 || id !== W'(100 + j)) begin errors++; $display("FAIL same_order[%0d]: got wr=%0b id=%0d want id=%0d", j, wr, id, 100 + j); end
    end
    issue_one(wm, wr, id);
    checks++; if (wr !== 1'b1 || id !== 9'd200) begin errors++; $display("FAIL same_tail: got wr=%0b id=%0d want wr=1 id=200", wr, id); end
    checks++; if (free_num !== 10'd0) begin errors++; $display("FAIL same_final_num: got %0d want 0", free_num); end
  endtask

  task automatic test_overflow;
    bit seen;
    int cyc;
    wait_first_wr(seen, cyc);
    checks++; if (!seen || bif.ov_bufid !== 9'd0) begin errors++; $display("FAIL ovf_reinit: got seen=%0b id=%0d want 1/0", seen, bif.ov_bufid); end
    release_one(9'd0);
    checks++; if (free_num !== 10'd512 || rel_err !== 1'b0) begin errors++; $display("FAIL ovf_fill: got num=%0d err=%0b want 512/0", free_num, rel_err); end
    release_one(9'd3);
    checks++; if (rel_err !== 1'b1) begin errors++; $display("FAIL ovf_rel_err: got %0b want 1", rel_err); end
    checks++; if (free_num !== 10'd512 || empty !== 1'b0) begin errors++; $display("FAIL ovf_count: got num=%0d empty=%0b want 512/0", free_num, empty); end
    @(negedge clk);
    checks++; if (rel_err !== 1'b0) begin errors++; $display("FAIL ovf_err_pulse: got %0b want 0", rel_err); end
  endtask

  task automatic test_double_free;
    bit seen;
    int cyc;
    logic wm, wr;
    logic [W-1:0] id;
    wait_first_wr(seen, cyc);
    for (int k = 1; k <= 7; k++) issue_one(wm, wr, id);
    checks++; if (id !== 9'd7 || free_num !== 10'd504) begin errors++; $display("FAIL dbl_setup: got id=%0d num=%0d want 7/504", id, free_num); end
    release_one(9'd7);
    checks++; if (rel_err !== 1'b0 || free_num !== 10'd505) begin errors++; $display("FAIL dbl_first: got err=%0b num=%0d want 0/505", rel_err, free_num); end
    release_one(9'd7);
`ifdef BUFID_DOUBLE_FREE_CHK_EN
    checks++; if (rel_err !== 1'b1 || free_num !== 10'd505) begin errors++; $display("FAIL dbl_second: got err=%0b num=%0d want 1/505", rel_err, free_num); end
`else
    checks++; if (rel_err !== 1'b0 || free_num !== 10'd506) begin errors++; $display("FAIL dbl_second: got err=%0b num=%0d want 0/506", rel_err, free_num); end
`endif
  endtask

  initial begin
    bif.i_bufid_req    = 1'b0;
    bif.i_bufid_rel_wr = 1'b0;
    bif.iv_bufid_rel   = '0;
    test_reset();
    test_init();
    test_latency();
    test_drain();
    test_release_empty();
    test_rel_pop_same();
    test_reset();
    test_overflow();
    test_reset();
    test_double_free();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
